// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one local command into one AXI4 INCR burst (AW/W/B or AR/R), one at a time.
// Defining AXI_4K_CHECK_EN rejects commands whose burst would cross a 4 KB boundary.
module axi_burst_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic                    done,
    output logic [1:0]              resp,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d, cnt_q, cnt_d;
    logic [1:0]              err_q, err_d, resp_q, resp_d, r_err;
    logic                    done_q, done_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    reject, r_final;

`ifdef AXI_4K_CHECK_EN
    assign reject = ((32'(cmd_addr) & 32'hFFF) + (32'(cmd_len) + 32'd1) * 32'(DATA_WIDTH/8)) > 32'd4096;
`else
    assign reject = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !done_q;
    assign awaddr    = addr_q;
    assign awlen     = len_q;
    assign awvalid   = state_q == AW;
    assign araddr    = addr_q;
    assign arlen     = len_q;
    assign arvalid   = state_q == AR;
    assign wvalid    = (state_q == W) && wr_valid;
    assign wr_ready  = (state_q == W) && wready;
    assign wdata     = (state_q == W) ? wr_data : '0;
    assign wstrb     = (state_q == W) ? '1 : '0;
    assign wlast     = (state_q == W) && (cnt_q == len_q);
    assign bready    = state_q == B;
    assign rready    = state_q == R;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign resp      = resp_q;

    // A read ends on rlast or when the beat count reaches len, whichever comes first.
    assign r_final = rlast || (cnt_q == len_q);
    assign r_err   = (err_q == OKAY) ? rresp : err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        resp_d     = resp_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                addr_d = cmd_addr;
                len_d  = cmd_len;
                cnt_d  = '0;
                err_d  = OKAY;
                if (reject) begin
                    done_d = 1'b1;
                    resp_d = SLVERR;
                end else
                    state_d = cmd_write ? AW : AR;
            end
            AW: state_d = awready ? W : AW;
            W: if (wr_valid && wready) begin
                cnt_d   = cnt_q + 8'd1;
                state_d = wlast ? B : W;
            end
            B: if (bvalid) begin
                resp_d  = bresp;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            AR: state_d = arready ? R : AR;
            R: if (rvalid) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rdata;
                rd_last_d  = r_final;
                cnt_d      = cnt_q + 8'd1;
                err_d      = r_err;
                if (r_final) begin
                    done_d  = 1'b1;
                    resp_d  = (r_err == OKAY && !(rlast && cnt_q == len_q)) ? SLVERR : r_err;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= OKAY;
            resp_q     <= OKAY;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            resp_q     <= resp_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: table-driven and randomized commands against an AXI slave/stream model in the bench.
module tb_axi_burst_master;
    localparam int AW_W = 16;
    localparam int DW = 32;
    localparam int MAXC = 500;
    localparam logic [31:0] WBASE = 32'hA0;
`ifdef AXI_4K_CHECK_EN
    localparam bit CHK4K = 1'b1;
`else
    localparam bit CHK4K = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        int          len;
        logic [1:0]  bresp;
        int          err_beat;
        logic [1:0]  err_code;
        int          rlast_at;
        int          aw_hold;
        bit          stall;
        logic [1:0]  exp_resp;
    } vec_t;

    logic            aclk = 1'b0, aresetn = 1'b0;
    logic            cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW_W-1:0] cmd_addr = '0;
    logic [7:0]      cmd_len = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            wr_valid = 1'b0, wr_ready;
    logic [DW-1:0]   rd_data;
    logic            rd_valid, rd_last, done;
    logic [1:0]      resp;
    logic [AW_W-1:0] awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic            awvalid, awready = 1'b0, arvalid, arready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast, wvalid, wready = 1'b0;
    logic [1:0]      bresp = '0;
    logic            bvalid = 1'b0, bready;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = '0;
    logic            rlast = 1'b0, rvalid = 1'b0, rready;

    int passed = 0, total = 0;

    axi_burst_master #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .resp(resp),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    function automatic bit rnd(input bit stall);
        return !stall || ($urandom_range(0, 2) != 0);
    endfunction

    function automatic logic [31:0] rd_pat(input int i);
        return 32'h11 * 32'(i + 1);
    endfunction

    function automatic bit model_reject(input vec_t v);
        int span;
        span = int'(v.addr & 16'h0FFF) + (v.len + 1) * (DW / 8);
        return CHK4K && span > 4096;
    endfunction

    // Beats the slave actually returns: up to its rlast, but never beyond len+1.
    function automatic int model_beats(input vec_t v);
        if (v.wr) return v.len + 1;
        return (v.rlast_at <= v.len) ? v.rlast_at + 1 : v.len + 1;
    endfunction

    function automatic logic [1:0] model_resp(input vec_t v);
        logic [1:0] r;
        if (model_reject(v)) return 2'b10;
        if (v.wr) return v.bresp;
        r = (v.err_beat < model_beats(v)) ? v.err_code : 2'b00;
        if (r == 2'b00 && v.rlast_at != v.len) r = 2'b10;
        return r;
    endfunction

    task automatic run(input vec_t v, input string tag);
        bit rej, fin, accepted, aw_ok, ar_ok, took_w, r_hs, b_hs, pa, pw, pr;
        int n_aw, n_ar, n_w, n_b, n_rd, bad, viol, nb, src, ridx, acc_cyc, done_cyc;
        logic [15:0] paddr;
        logic [7:0]  plen;
        logic [31:0] pdata;
        logic        plast;
        logic [1:0]  got;
        rej = model_reject(v); nb = model_beats(v);
        fin = 0; accepted = 0; aw_ok = 0; ar_ok = 0; took_w = 0; r_hs = 0; b_hs = 0;
        pa = 0; pw = 0; pr = 0; n_aw = 0; n_ar = 0; n_w = 0; n_b = 0; n_rd = 0;
        bad = 0; viol = 0; src = 0; ridx = 0; acc_cyc = -1; done_cyc = -1; got = 2'b00;
        paddr = '0; plen = '0; pdata = '0; plast = 1'b0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = 8'(v.len);
        wr_valid = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        for (int c = 0; c < MAXC && !fin; c++) begin
            if (accepted) cmd_valid = 1'b0;
            awready = (c >= v.aw_hold) && rnd(v.stall);
            arready = rnd(v.stall);
            wready  = rnd(v.stall);
            if (took_w) src++;
            if (!wr_valid || took_w) begin
                wr_valid = v.wr && src <= v.len && rnd(v.stall);
                wr_data  = WBASE + 32'(src);
            end
            bresp = v.bresp;
            if (b_hs) bvalid = 1'b0;
            else if (!bvalid && n_b == 0 && n_w == v.len + 1) bvalid = rnd(v.stall);
            if (r_hs) ridx++;
            if (!rvalid || r_hs) begin
                rvalid = ar_ok && ridx < nb && rnd(v.stall);
                rdata  = rd_pat(ridx);
                rresp  = (ridx == v.err_beat) ? v.err_code : 2'b00;
                rlast  = ridx == v.rlast_at;
            end
            #1;
            if (cmd_valid && cmd_ready && !accepted) begin accepted = 1; acc_cyc = c; end
            if (pa && (!awvalid || awaddr !== paddr || awlen !== plen)) viol++;
            if (pr && (!arvalid || araddr !== paddr || arlen !== plen)) viol++;
            if (pw && (!wvalid || wdata !== pdata || wlast !== plast)) viol++;
            if (wvalid && !aw_ok) viol++;
            if (rej && (wr_ready || awvalid || arvalid)) viol++;
            if (awvalid && awready) begin
                n_aw++; aw_ok = 1;
                if (awaddr !== v.addr || awlen !== 8'(v.len)) bad++;
            end
            took_w = wvalid && wready;
            if (took_w) begin
                if (wdata !== WBASE + 32'(n_w) || wlast !== (n_w == v.len) || wstrb !== 4'hF) bad++;
                n_w++;
            end
            b_hs = bvalid && bready;
            if (b_hs) n_b++;
            if (arvalid && arready) begin
                n_ar++; ar_ok = 1;
                if (araddr !== v.addr || arlen !== 8'(v.len)) bad++;
            end
            r_hs = rvalid && rready;
            if (rd_valid) begin
                if (rd_data !== rd_pat(n_rd) || rd_last !== (n_rd == nb - 1)) bad++;
                n_rd++;
            end
            if (done) begin
                fin = 1; got = resp; done_cyc = c;
                if (cmd_ready) bad++;
                if (!v.wr && !rej && !rd_valid) bad++;
            end
            pa = awvalid && !awready; pr = arvalid && !arready; pw = wvalid && !wready;
            paddr = awvalid ? awaddr : araddr; plen = awvalid ? awlen : arlen;
            pdata = wdata; plast = wlast;
            @(negedge aclk);
        end
        cmd_valid = 1'b0; wr_valid = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        awready = 1'b0; arready = 1'b0; wready = 1'b0;
        #1;
        chk({tag, "_done"}, 64'(fin), 64'd1);
        chk({tag, "_resp"}, 64'(got), 64'(v.exp_resp));
        chk({tag, "_aw"}, 64'(n_aw), 64'(v.wr && !rej));
        chk({tag, "_ar"}, 64'(n_ar), 64'(!v.wr && !rej));
        chk({tag, "_wbeats"}, 64'(n_w), (v.wr && !rej) ? 64'(v.len + 1) : 64'd0);
        chk({tag, "_rbeats"}, 64'(n_rd), (!v.wr && !rej) ? 64'(nb) : 64'd0);
        chk({tag, "_payload"}, 64'(bad), 64'd0);
        chk({tag, "_stable"}, 64'(viol), 64'd0);
        chk({tag, "_idle_after"}, {62'd0, done, cmd_ready}, 64'd1);
        if (rej) chk({tag, "_rej_lat"}, 64'(done_cyc - acc_cyc), 64'd1);
    endtask

    initial begin
        vec_t vecs[9];
        vec_t v;
        int nw;
        bit acc;
        vecs[0] = '{1, 16'h0100, 3, 2'b00, 99, 2'b00, 3, 0, 0, 2'b00};
        vecs[1] = '{0, 16'h0200, 1, 2'b00, 1, 2'b10, 1, 0, 0, 2'b10};
        vecs[2] = '{1, 16'h0400, 3, 2'b11, 99, 2'b00, 3, 6, 1, 2'b11};
        vecs[3] = '{0, 16'h0500, 3, 2'b00, 99, 2'b00, 2, 0, 0, 2'b10};
        vecs[4] = '{0, 16'h0600, 2, 2'b00, 99, 2'b00, 9, 0, 1, 2'b10};
        vecs[5] = '{0, 16'h0700, 0, 2'b00, 99, 2'b00, 0, 0, 0, 2'b00};
        vecs[6] = '{1, 16'h0FF8, 3, 2'b00, 99, 2'b00, 3, 0, 0, CHK4K ? 2'b10 : 2'b00};
        vecs[7] = '{0, 16'h0800, 7, 2'b00, 3, 2'b11, 7, 0, 1, 2'b11};
        vecs[8] = '{1, 16'h0900, 0, 2'b10, 99, 2'b00, 0, 0, 1, 2'b10};

        repeat (3) @(negedge aclk);
        #1;
        chk("reset_ctrl", {54'd0, awvalid, wvalid, arvalid, bready, rready, done, rd_valid, rd_last, wlast, wr_ready}, 64'd0);
        chk("reset_data", {awaddr, awlen, resp, araddr}, 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 9; i++) run(vecs[i], $sformatf("vec%0d", i));

        // Abort a write after two of four beats.
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0300; cmd_len = 8'd3;
        awready = 1'b1; wready = 1'b1; wr_valid = 1'b1; wr_data = 32'hB0; nw = 0; acc = 0;
        for (int c = 0; c < 50 && nw < 2; c++) begin
            #1;
            if (cmd_valid && cmd_ready) acc = 1;
            if (wvalid && wready) nw++;
            @(negedge aclk);
            if (acc) cmd_valid = 1'b0;
            wr_data = 32'hB0 + 32'(nw);
        end
        chk("rst_mid_beats", 64'(nw), 64'd2);
        chk("rst_mid_in_w", 64'(wvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("rst_mid_outs", {55'd0, awvalid, wvalid, arvalid, bready, rready, wr_ready, done, rd_valid, wlast}, 64'd0);
        cmd_valid = 1'b0; wr_valid = 1'b0; awready = 1'b0; wready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rst_release", {62'd0, cmd_ready, done}, 64'd2);
        run('{0, 16'h0A00, 1, 2'b00, 99, 2'b00, 1, 0, 0, 2'b00}, "after_rst");

        for (int i = 0; i < 25; i++) begin
            v.wr       = 1'($urandom_range(0, 1));
            v.addr     = 16'($urandom_range(0, 16'h3FFF)) << 2;
            v.len      = $urandom_range(0, 7);
            v.bresp    = 2'($urandom_range(0, 3));
            v.err_beat = $urandom_range(0, 9);
            v.err_code = 2'($urandom_range(0, 3));
            v.rlast_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : v.len;
            v.aw_hold  = $urandom_range(0, 3);
            v.stall    = 1'b1;
            v.exp_resp = model_resp(v);
            run(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
